// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage / MEM-WB register: FSM states, word geometry,
// and the alignment rule used by the load/store path.
package mem_wb_stage_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFS_W = 2;
    localparam int unsigned REG_W      = 5;

    typedef enum logic {
        STATE_CLEAR = 1'b0,
        STATE_RUN   = 1'b1
    } state_t;

    function automatic logic misaligned(input logic access, input logic [BYTE_OFS_W-1:0] ofs);
        return access & (ofs != '0);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EXE/MEM-side inputs and MEM/WB-side outputs of the MEM stage, bundled as one bus.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic              MEM_MemtoReg;
    logic              MEM_MemWr;
    logic              MEM_RegWr;
    logic [REG_W-1:0]  MEM_Rw;
    logic [WORD_W-1:0] MEM_Result;
    logic [WORD_W-1:0] MEM_BusB;

    logic              WB_MemtoReg;
    logic              WB_RegWr;
    logic [REG_W-1:0]  WB_Rw;
    logic [WORD_W-1:0] WB_Result;
    logic [WORD_W-1:0] WB_Dout;
    logic [WORD_W-1:0] WB_BusW;
    logic              MemBusy;
    logic              MemAlignErr;

    modport master (
        output MEM_MemtoReg, MEM_MemWr, MEM_RegWr, MEM_Rw, MEM_Result, MEM_BusB,
        input  WB_MemtoReg, WB_RegWr, WB_Rw, WB_Result, WB_Dout, WB_BusW,
        input  MemBusy, MemAlignErr
    );

    modport slave (
        input  MEM_MemtoReg, MEM_MemWr, MEM_RegWr, MEM_Rw, MEM_Result, MEM_BusB,
        output WB_MemtoReg, WB_RegWr, WB_Rw, WB_Result, WB_Dout, WB_BusW,
        output MemBusy, MemAlignErr
    );

endinterface

// File: rtl/mem_wb_stage_data_ram.sv
// Single-port word RAM: synchronous write, asynchronous read on the same address.
module mem_wb_stage_data_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register of the 5-stage MIPS pipeline, with a post-reset
// sequencer that zeroes data memory while holding MemBusy high.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W         = 6,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic           CLK,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    logic              wb_memtoreg;
    logic              wb_regwr;
    logic [REG_W-1:0]  wb_rw;
    logic [WORD_W-1:0] wb_result;
    logic [WORD_W-1:0] wb_dout;
    logic              align_err;

    logic [ADDR_W-1:0] idx;
    logic              misalign;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    // Upper address bits are dropped, so addresses alias modulo DEPTH words.
    assign idx      = bus.MEM_Result[ADDR_W+1:BYTE_OFS_W];
    assign misalign = misaligned(bus.MEM_MemWr | bus.MEM_MemtoReg, bus.MEM_Result[1:0]);

    // The single RAM port is owned by the clear sweep in CLEAR, by the store path in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = idx;
        ram_wdata = bus.MEM_BusB;
        if (state == STATE_CLEAR) begin
            ram_we    = reset;
            ram_addr  = clr_addr;
            ram_wdata = '0;
        end else begin
            ram_we = reset & bus.MEM_MemWr & ~misalign;
        end
    end

    mem_wb_stage_data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_data_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state       <= CLEAR_ON_RESET ? STATE_CLEAR : STATE_RUN;
            clr_addr    <= '0;
            wb_memtoreg <= 1'b0;
            wb_regwr    <= 1'b0;
            wb_rw       <= '0;
            wb_result   <= '0;
            wb_dout     <= '0;
            align_err   <= 1'b0;
        end else begin
            case (state)
                STATE_CLEAR: begin
                    clr_addr    <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= STATE_RUN;
                    end
                    wb_memtoreg <= 1'b0;
                    wb_regwr    <= 1'b0;
                    wb_rw       <= '0;
                    wb_result   <= '0;
                    wb_dout     <= '0;
                end
                default: begin
                    wb_memtoreg <= bus.MEM_MemtoReg;
                    wb_regwr    <= bus.MEM_RegWr & ~(misalign & bus.MEM_MemtoReg);
                    wb_rw       <= bus.MEM_Rw;
                    wb_result   <= bus.MEM_Result;
                    wb_dout     <= ram_rdata;
                    if (misalign) begin
                        align_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.WB_MemtoReg = wb_memtoreg;
    assign bus.WB_RegWr    = wb_regwr;
    assign bus.WB_Rw       = wb_rw;
    assign bus.WB_Result   = wb_result;
    assign bus.WB_Dout     = wb_dout;
    assign bus.WB_BusW     = wb_memtoreg ? wb_dout : wb_result;
    assign bus.MemBusy     = (state == STATE_CLEAR);
    assign bus.MemAlignErr = align_err;

endmodule
